// File: rtl/screensaver_pkg.sv
// Shared types and constants for the screensaver pattern sequencer:
// sequencer state encoding, fade level range and packed RGB pixel.
package screensaver_pkg;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } seq_state_t;

  localparam int LEVEL_MAX = 16;
  localparam int LEVEL_W   = $clog2(LEVEL_MAX) + 1;
  localparam int COLOR_W   = 4;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/pattern_sequencer_if.sv
// Bundle between the pattern generators / VGA timing block and the sequencer.
// master = sequencer side, slave = generators, timing block and output stage.
interface pattern_sequencer_if
  import screensaver_pkg::*;
#(
  parameter int NUM_PATTERNS = 3
) ();

  localparam int SEL_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;

  logic                            frame_tick;
  logic                            next_req;
  logic [NUM_PATTERNS*3*COLOR_W-1:0] rgb_in;
  logic [31:0]                     frame;
  logic [SEL_W-1:0]                sel;
  logic [NUM_PATTERNS-1:0]         pattern_rst;
  logic [COLOR_W-1:0]              r;
  logic [COLOR_W-1:0]              g;
  logic [COLOR_W-1:0]              b;

  modport master (
    input  frame_tick, next_req, rgb_in,
    output frame, sel, pattern_rst, r, g, b
  );

  modport slave (
    output frame_tick, next_req, rgb_in,
    input  frame, sel, pattern_rst, r, g, b
  );

endinterface

// File: rtl/fade_scaler.sv
// Combinational colour scaler: out = (c * level) >> 4, so level 16 is unity.
// Only present when PATTERN_SEQUENCER_FADE_EN is defined.
`ifdef PATTERN_SEQUENCER_FADE_EN
module fade_scaler
  import screensaver_pkg::*;
(
  input  logic [COLOR_W-1:0] c,
  input  logic [LEVEL_W-1:0] level,
  output logic [COLOR_W-1:0] out
);

  // 4b x 5b product never exceeds 240, so bits [7:4] hold the whole result.
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] cv,
                                               input logic [LEVEL_W-1:0] lv);
    return COLOR_W'(({4'b0, cv} * {3'b0, lv}) >> 4);
  endfunction

  assign out = scale(c, level);

endmodule
`endif

// File: rtl/pattern_sequencer.sv
// Screensaver pattern sequencer: frame counter, pattern select, dwell timer and
// fade FSM. PATTERN_SEQUENCER_FADE_EN enables the 16-step fade; otherwise one black frame.
module pattern_sequencer
  import screensaver_pkg::*;
#(
  parameter int NUM_PATTERNS = 3,
  parameter int DWELL_FRAMES = 600
) (
  input  logic                clk,
  input  logic                rst,
  pattern_sequencer_if.master bus
);

  localparam int SEL_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam int RGB_W = 3 * COLOR_W;

  seq_state_t              state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [31:0]             frame_q, frame_d;
  logic [31:0]             dwell_q, dwell_d;
  logic [NUM_PATTERNS-1:0] prst_q, prst_d;
  rgb_t                    rgb_q, rgb_d;
  rgb_t                    pix;

`ifdef PATTERN_SEQUENCER_FADE_EN
  logic [LEVEL_W-1:0]      level_q, level_d;
  rgb_t                    scaled;
`endif

  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(NUM_PATTERNS - 1)) ? '0 : s + 1'b1;
  endfunction

  always_comb begin
    pix = '0;
    for (int k = 0; k < NUM_PATTERNS; k++) begin
      if (sel_q == SEL_W'(k)) pix = bus.rgb_in[k*RGB_W +: RGB_W];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    frame_d = frame_q;
    dwell_d = dwell_q;
    prst_d  = '0;
`ifdef PATTERN_SEQUENCER_FADE_EN
    level_d = level_q;
`endif
    if (bus.frame_tick) frame_d = frame_q + 32'd1;

    case (state_q)
      SHOW: begin
        if (bus.frame_tick) begin
          dwell_d = dwell_q + 32'd1;
          if (dwell_q == 32'(DWELL_FRAMES - 1)) state_d = FADE_OUT;
        end
        if (bus.next_req) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (bus.frame_tick) begin
`ifdef PATTERN_SEQUENCER_FADE_EN
          level_d = level_q - 1'b1;
          if (level_q == LEVEL_W'(1)) state_d = SWAP;
`else
          state_d = SWAP;
`endif
        end
      end
      SWAP: begin
        frame_d = '0;
        state_d = FADE_IN;
      end
      FADE_IN: begin
        if (bus.frame_tick) begin
`ifdef PATTERN_SEQUENCER_FADE_EN
          level_d = level_q + 1'b1;
          if (level_q == LEVEL_W'(LEVEL_MAX - 1)) state_d = SHOW;
`else
          state_d = SHOW;
`endif
        end
      end
      default: state_d = SHOW;
    endcase

    // Swap side effects land on the entry edge so they are visible during SWAP.
    if (state_d == SWAP) begin
      sel_d   = next_sel(sel_q);
      frame_d = '0;
      dwell_d = '0;
      for (int k = 0; k < NUM_PATTERNS; k++) prst_d[k] = (sel_d == SEL_W'(k));
    end
  end

`ifdef PATTERN_SEQUENCER_FADE_EN
  fade_scaler u_scale_r (.c(pix.r), .level(level_q), .out(scaled.r));
  fade_scaler u_scale_g (.c(pix.g), .level(level_q), .out(scaled.g));
  fade_scaler u_scale_b (.c(pix.b), .level(level_q), .out(scaled.b));
  assign rgb_d = scaled;
`else
  assign rgb_d = (state_q == SHOW) ? pix : '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      sel_q   <= '0;
      frame_q <= '0;
      dwell_q <= '0;
      prst_q  <= '0;
      rgb_q   <= '0;
`ifdef PATTERN_SEQUENCER_FADE_EN
      level_q <= LEVEL_W'(LEVEL_MAX);
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      dwell_q <= dwell_d;
      prst_q  <= prst_d;
      rgb_q   <= rgb_d;
`ifdef PATTERN_SEQUENCER_FADE_EN
      level_q <= level_d;
`endif
    end
  end

  assign bus.frame       = frame_q;
  assign bus.sel         = sel_q;
  assign bus.pattern_rst = prst_q | {NUM_PATTERNS{rst}};
  assign bus.r           = rgb_q.r;
  assign bus.g           = rgb_q.g;
  assign bus.b           = rgb_q.b;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer (3 patterns, 600-frame dwell); follows
// PATTERN_SEQUENCER_FADE_EN to pick fade or black-frame expectations.
module tb_pattern_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  pattern_sequencer_if #(.NUM_PATTERNS(3)) bus ();

  pattern_sequencer #(.NUM_PATTERNS(3), .DWELL_FRAMES(600)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rgb_out();
    return {bus.r, bus.g, bus.b};
  endfunction

  // Pulse frame_tick; return #1 after the edge that sampled it.
  task automatic tick_edge();
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
  endtask

  task automatic tick();
    tick_edge();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic req();
    bus.next_req = 1'b1;
    @(posedge clk); #1;
    bus.next_req = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.next_req   = 1'b0;
    bus.rgb_in     = {12'h1C9, 12'h5A3, 12'hFFF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_prst",  32'(bus.pattern_rst), 32'h7);
    chk("rst_sel",   32'(bus.sel),         32'h0);
    chk("rst_frame", bus.frame,            32'h0);
    chk("rst_rgb",   32'(rgb_out()),       32'h000);

    rst = 1'b0;
    @(posedge clk); #1;
    chk("show_rgb0",  32'(rgb_out()),       32'hFFF);
    chk("show_prst0", 32'(bus.pattern_rst), 32'h0);

    repeat (599) tick();
    chk("dwell_frame", bus.frame,      32'd599);
    chk("dwell_sel",   32'(bus.sel),   32'h0);
    chk("dwell_rgb",   32'(rgb_out()), 32'hFFF);

    tick();
    chk("fo_frame", bus.frame, 32'd600);
`ifdef PATTERN_SEQUENCER_FADE_EN
    chk("fo_rgb16", 32'(rgb_out()), 32'hFFF);
    repeat (8) tick();
    chk("fo_rgb8", 32'(rgb_out()), 32'h777);
    repeat (7) tick();
    chk("fo_rgb1",   32'(rgb_out()), 32'h000);
    chk("fo_frame1", bus.frame,      32'd615);
`else
    chk("fo_black", 32'(rgb_out()), 32'h000);
`endif
    tick_edge();
    chk("swap1_sel",   32'(bus.sel),         32'h1);
    chk("swap1_prst",  32'(bus.pattern_rst), 32'h2);
    chk("swap1_frame", bus.frame,            32'h0);
    @(posedge clk); #1;
    chk("swap1_prst_off", 32'(bus.pattern_rst), 32'h0);
`ifdef PATTERN_SEQUENCER_FADE_EN
    repeat (8) tick();
    chk("fi_rgb8", 32'(rgb_out()), 32'h251);
    repeat (8) tick();
`else
    chk("fi_black", 32'(rgb_out()), 32'h000);
    tick();
`endif
    chk("p1_rgb", 32'(rgb_out()), 32'h5A3);
    chk("p1_sel", 32'(bus.sel),   32'h1);

    repeat (10) tick();
`ifdef PATTERN_SEQUENCER_FADE_EN
    chk("p1_frame", bus.frame, 32'd26);
    req();
    tick();
    chk("req_fo_rgb15", 32'(rgb_out()), 32'h492);
    repeat (14) tick();
`else
    chk("p1_frame", bus.frame, 32'd11);
    req();
    @(posedge clk); #1;
    chk("req_fo_black", 32'(rgb_out()), 32'h000);
`endif
    tick_edge();
    chk("swap2_sel",  32'(bus.sel),         32'h2);
    chk("swap2_prst", 32'(bus.pattern_rst), 32'h4);
    @(posedge clk); #1;
`ifdef PATTERN_SEQUENCER_FADE_EN
    repeat (4) tick();
    req();
    tick();
    chk("fi_ignore_req", 32'(rgb_out()), 32'h032);
    repeat (11) tick();
`else
    req();
    tick();
`endif
    chk("p2_rgb", 32'(rgb_out()), 32'h1C9);
    chk("p2_sel", 32'(bus.sel),   32'h2);

    req();
`ifdef PATTERN_SEQUENCER_FADE_EN
    repeat (15) tick();
`endif
    tick_edge();
    chk("wrap_sel",  32'(bus.sel),         32'h0);
    chk("wrap_prst", 32'(bus.pattern_rst), 32'h1);
    @(posedge clk); #1;
    chk("wrap_prst_off", 32'(bus.pattern_rst), 32'h0);
`ifdef PATTERN_SEQUENCER_FADE_EN
    repeat (5) tick();
    chk("fi5_rgb",   32'(rgb_out()), 32'h444);
    chk("fi5_frame", bus.frame,      32'd5);
`else
    chk("fi_wrap_black", 32'(rgb_out()), 32'h000);
`endif

    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_prst",  32'(bus.pattern_rst), 32'h7);
    chk("mid_rst_sel",   32'(bus.sel),         32'h0);
    chk("mid_rst_frame", bus.frame,            32'h0);
    chk("mid_rst_rgb",   32'(rgb_out()),       32'h000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rgb", 32'(rgb_out()), 32'hFFF);
    repeat (3) tick();
    chk("post_rst_frame", bus.frame,      32'd3);
    chk("post_rst_rgb3",  32'(rgb_out()), 32'hFFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Sequences the screensaver's pattern generators (checkerboard, fractal, bouncing box). Owns the shared frame counter. Selects which generator drives the VGA output, dwells a fixed number of frames per pattern, and switches on timeout or user request with a frame-synchronous fade-out/fade-in. Sits between the generator instances and the VGA output register stage; `frame_tick` comes from the VGA timing block.

## Interface
- `NUM_PATTERNS`, default 3: number of generator instances; legal range 2..4.
- `DWELL_FRAMES`, default 600: frames shown per pattern before an automatic switch; must be ≥2.
- `clk` input 1: pixel clock.
- `rst` input 1: reset; synchronous, active-high.
- `frame_tick` input 1: one-cycle pulse at the start of vertical blank.
- `next_req` input 1: one-cycle pulse (debounced button) requesting an immediate switch.
- `rgb_in` input NUM_PATTERNS*12: generator outputs. Pattern k occupies [12k+11:12k] as {r,g,b}, 4 bits each.
- `frame` output 32: frame counter fed to all generators.
- `sel` output $clog2(NUM_PATTERNS): index of the displayed pattern.
- `pattern_rst` output NUM_PATTERNS: per-generator synchronous reset.
- `r`, `g`, `b` output 4 each: registered, faded output color.

## Operation
- States: SHOW, FADE_OUT, SWAP, FADE_IN.
- Reset values:
  - state = SHOW, sel = 0, level = 16, frame = 0, dwell = 0, r/g/b = 0.
  - `pattern_rst` = all ones while `rst` is high.
- `frame` increments by 1 on every `frame_tick` in every state except SWAP, and wraps at 2^32. It is set to 0 in SWAP.
- SHOW:
  - dwell increments on each tick.
  - A tick with dwell == DWELL_FRAMES-1 goes to FADE_OUT.
  - `next_req` goes to FADE_OUT on the following cycle, regardless of tick.
  - If `next_req` and the dwell-expiry tick coincide, there is a single transition.
- FADE_OUT: level decrements by 1 per tick. The tick that makes level 0 goes to SWAP.
- SWAP: lasts exactly one cycle.
  - sel ← (sel == NUM_PATTERNS-1) ? 0 : sel+1.
  - `pattern_rst[new sel]` pulses high for that one cycle only.
  - frame ← 0, dwell ← 0.
  - Next state is FADE_IN.
- FADE_IN: level increments by 1 per tick. The tick that makes level 16 goes to SHOW.
- `next_req` outside SHOW is ignored; it is not queued.
- Color scaling: out = (c × level) >> 4. c is 4 bits and level is 5 bits (0..16); the product is 9 bits and [7:4] is taken. Level 16 reproduces c exactly; level 0 gives black.
- Output mux: c = rgb_in slice at `sel`.

## Timing
- r/g/b are registered one cycle after `rgb_in`/`sel`. Generators consume `position_*_next`, so the total pipeline matches the VGA timing block.
- level changes only on `frame_tick`, so brightness never changes mid-frame.
- An asserted `rst` mid-fade returns to the reset values on the next edge. The fade in progress is abandoned.
- Full automatic cycle = DWELL_FRAMES + 16 + 16 ticks, plus 1 SWAP cycle.

## Configuration
- `PATTERN_SEQUENCER_FADE_EN` defined:
  - Fade behaves as described above: 16 ticks out, 16 ticks in.
- Undefined:
  - The level register and scaler are removed.
  - r/g/b are forced to 0 in FADE_OUT, SWAP and FADE_IN, and pass through unchanged in SHOW.
  - FADE_OUT and FADE_IN each last exactly one tick, giving one black frame before and after the swap.

## Structure
- `screensaver_pkg`:
  - state enum `seq_state_t`
  - `LEVEL_MAX` = 16
  - `COLOR_W` = 4
  - typedef `rgb_t` (packed r,g,b)
- Sub-module `fade_scaler`: combinational 4-bit × 5-bit → 4-bit, instantiated three times. It is excluded when the macro is undefined.

## Test plan
- Reset, then tick 599 times: sel = 0, r/g/b = rgb_in[11:0], frame = 599. Tick 600 enters FADE_OUT.
- With rgb_in pattern 0 = 12'hFFF: after 8 FADE_OUT ticks level = 8 and r/g/b = 4'h7. After 16 ticks, SWAP: sel = 1, `pattern_rst` = 3'b010 for exactly one cycle, frame = 0.
- `next_req` pulse in SHOW at dwell = 10: FADE_OUT begins next cycle. A second `next_req` during FADE_IN leaves state unchanged.
- With NUM_PATTERNS = 3, three switches starting at sel = 2 wrap sel to 0; `pattern_rst` = 3'b001 pulses.
- `rst` asserted during FADE_IN at level 5: the next cycle shows level = 16, sel = 0, frame = 0, state SHOW.
- Macro undefined: a `next_req` produces exactly one black frame, SWAP, one black frame, then full-brightness pattern 1.
